// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;
  localparam int         WB_XLEN  = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ALU_PRI = 1'b0,
    LD_PRI  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

  // Starvation counter width; never narrower than one bit.
  function automatic int cnt_width(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction
endpackage

// File: rtl/rf_wb_starve_ctr.sv
// Load anti-starvation counter and ALU_PRI/LD_PRI state machine; ld_pri selects load priority.
module rf_wb_starve_ctr
  import rf_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic ld_valid,
  input  logic ld_grant,
  output logic ld_pri
);
  localparam int             CW        = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0]  LIM       = CW'(STARVE_LIMIT);
  localparam arb_state_e     RST_STATE = (STARVE_LIMIT == 0) ? LD_PRI : ALU_PRI;

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q >= LIM) ? LIM : cnt_q + 1'b1;
    if (STARVE_LIMIT == 0) begin
      // Loads always win: park in LD_PRI permanently.
      state_d = LD_PRI;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ALU_PRI: begin
          if (ld_valid && !ld_grant) begin
            cnt_d = cnt_inc;
            if (cnt_inc == LIM) state_d = LD_PRI;
          end else begin
            cnt_d = '0;
          end
        end
        LD_PRI: begin
          // Either the load got its slot or it withdrew; both end the episode.
          if (ld_grant || !ld_valid) begin
            state_d = ALU_PRI;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ALU_PRI;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign ld_pri = (state_q == LD_PRI);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
// Optional macro RF_WB_BYPASS_EN adds decode-side forwarding of the output-stage write.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int XLEN         = WB_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
`ifdef RF_WB_BYPASS_EN
  input  logic [4:0]      byp_rs1,
  input  logic [4:0]      byp_rs2,
  output logic            byp_hit1,
  output logic            byp_hit2,
  output logic [XLEN-1:0] byp_data,
`endif
  output logic            starve_active
);
  logic    ld_pri;
  wb_req_t win;
  logic    win_vld;

  rf_wb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_grant (ld_ready),
    .ld_pri   (ld_pri)
  );

  // Readiness depends only on valids and priority state, never on payload.
  assign alu_ready     = alu_valid && (!ld_pri || !ld_valid);
  assign ld_ready      = ld_valid && (ld_pri || !alu_valid);
  assign starve_active = ld_pri;

  always_comb begin
    win     = '{rd: alu_rd, data: alu_data};
    win_vld = alu_ready;
    if (ld_ready) begin
      win     = '{rd: ld_rd, data: ld_data};
      win_vld = 1'b1;
    end
  end

  // x0 writes are consumed here: accepted but never strobed to the file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= REG_ZERO;
      rf_wd <= '0;
    end else begin
      rf_we <= win_vld && (win.rd != REG_ZERO);
      if (win_vld && (win.rd != REG_ZERO)) begin
        rf_wa <= win.rd;
        rf_wd <= win.data;
      end
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign byp_hit1 = rf_we && (rf_wa == byp_rs1) && (byp_rs1 != REG_ZERO);
  assign byp_hit2 = rf_we && (rf_wa == byp_rs2) && (byp_rs2 != REG_ZERO);
  assign byp_data = rf_wd;
`endif
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file (x0 hardwired zero, write on posedge clk) between two writeback requesters: the ALU/execute path and the multi-cycle load unit.
- Arbitrates with ALU-priority plus an anti-starvation counter for loads.
- Registers the winning write into a one-deep output stage that drives the register file write port (we/wa/wd).
- Sits between execute/memory stages and the register file.

Parameters:
- STARVE_LIMIT, 3: consecutive cycles a valid load may lose arbitration before it gets priority. 0 means loads always win.
- XLEN, 32: data width.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU request accepted this cycle
- alu_rd  input  5  ALU destination register
- alu_data  input  XLEN  ALU result
- ld_valid  input  1  load writeback request
- ld_ready  output  1  load request accepted this cycle
- ld_rd  input  5  load destination register
- ld_data  input  XLEN  load data
- rf_we  output  1  to register file we
- rf_wa  output  5  to register file wa
- rf_wd  output  XLEN  to register file wd
- starve_active  output  1  arbiter currently in load-priority state

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous and active-high.
  - Reset values: rf_we=0, rf_wa=0, rf_wd=0, state=ALU_PRI, starve_cnt=0, starve_active=0.
- Handshake:
  - A transfer occurs when valid && ready.
  - A requester holds rd/data stable while valid && !ready.
  - ready is combinational from the valid inputs and state only, never from payload.
- Grant:
  - At most one grant per cycle.
  - In ALU_PRI, the ALU wins if alu_valid; otherwise the load wins if ld_valid.
  - In LD_PRI, the load wins if ld_valid; otherwise the ALU wins.
  - A requester with valid=0 is never granted.
- Latency:
  - The accepted write appears on rf_we/rf_wa/rf_wd the cycle after the transfer.
  - The register file commits it on the following posedge, so a write is visible to readers 2 edges after acceptance.
- Output stage:
  - Updated every cycle.
  - rf_we=1 only if a transfer occurred with rd != 0.
  - When rf_we=0, rf_wa/rf_wd hold their previous values.
- x0 writes:
  - Accepted (ready asserted) and consumed silently; rf_we stays 0.
  - Still counts as a grant for arbitration state.
- FSM states: ALU_PRI, LD_PRI.
  - ALU_PRI: starve_cnt increments (saturating) each cycle where ld_valid && !ld_ready.
  - ALU_PRI: starve_cnt clears when a load is granted or ld_valid=0.
  - ALU_PRI -> LD_PRI at the clock edge where the incremented count reaches STARVE_LIMIT.
  - LD_PRI -> ALU_PRI on a load grant; starve_cnt clears.
  - LD_PRI with ld_valid=0 (requester withdrew): return to ALU_PRI.
  - starve_active = (state==LD_PRI).
  - STARVE_LIMIT=0: FSM held in LD_PRI.
- Counter width: $clog2(STARVE_LIMIT+1), minimum 1.
- Simultaneous requests to the same rd: writes commit in grant order; the last granted value persists.
- Reset mid-operation: the in-flight output-stage write is discarded (rf_we forced 0). Requesters re-present after reset.

Optional Feature:
- RF_WB_BYPASS_EN adds ports: byp_rs1/byp_rs2 input 5; byp_hit1/byp_hit2 output 1; byp_data output XLEN.
- With the macro defined:
  - byp_hitN = rf_we && rf_wa==byp_rsN && byp_rsN!=0.
  - byp_data = rf_wd.
  - Lets decode forward the write still in the output stage.
- Without the macro: these ports and logic are absent.

Decomposition:
- Shared package rf_wb_pkg:
  - typedef arb_state_e {ALU_PRI, LD_PRI}.
  - struct wb_req_t {rd[4:0], data[XLEN-1:0]}.
  - REG_ZERO constant 5'd0.
- One natural sub-module: rf_wb_starve_ctr. It holds the saturating counter plus the FSM and outputs the priority select.
- Grant muxing and the output stage stay in the top.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF -> alu_ready=1 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=DEADBEEF.
- Both valid, STARVE_LIMIT=3, ALU continuously valid:
  - ld_ready=0 for 3 cycles, then starve_active=1.
  - Load granted on the 4th cycle and ALU stalled that cycle.
  - The following cycle returns to ALU_PRI.
- x0 write: ld_valid=1, ld_rd=0, ld_data=32'h1234 -> ld_ready=1; next cycle rf_we=0, rf_wa/rf_wd unchanged.
- Same rd from both: ALU rd=7 data=1 and load rd=7 data=2 in the same cycle, ALU_PRI -> rf_wd=1 then 2 on consecutive cycles; final x7=2.
- Async reset mid-op: assert rst between edges while rf_we=1 -> rf_we drops to 0 immediately, no register file write on the next edge, FSM in ALU_PRI.
- RF_WB_BYPASS_EN: rf_we=1, rf_wa=9, rf_wd=32'hA5A5A5A5, byp_rs1=9, byp_rs2=0 -> byp_hit1=1, byp_hit2=0, byp_data=A5A5A5A5.
